// File: rtl/frame_buffer_arbiter_if.sv
// Requester and BRAM-port signal bundle for the frame buffer arbiter.
// slave: the arbiter's view. master: the view of the surrounding requesters and BRAM.
interface frame_buffer_arbiter_if #(
    parameter int unsigned ADDR_W = 19
);
    // VGA scan-out reader
    logic              vga_req;
    logic [15:0]       vga_row;
    logic [15:0]       vga_col;
    logic              vga_gnt;
    logic              vga_rvalid;

    // Sobel window reader
    logic              sob_rd_req;
    logic [15:0]       sob_rd_row;
    logic [15:0]       sob_rd_col;
    logic              sob_rd_gnt;
    logic              sob_rd_rvalid;

    // Sobel result writer
    logic              sob_wr_req;
    logic [15:0]       sob_wr_row;
    logic [15:0]       sob_wr_col;
    logic [7:0]        sob_wr_data;
    logic              sob_wr_gnt;

    // Shared read return and status
    logic [7:0]        rd_data;
    logic              oob_err;

    // BRAM port
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_wdata;
    logic [7:0]        bram_rdata;

    modport slave (
        input  vga_req, vga_row, vga_col,
        output vga_gnt, vga_rvalid,
        input  sob_rd_req, sob_rd_row, sob_rd_col,
        output sob_rd_gnt, sob_rd_rvalid,
        input  sob_wr_req, sob_wr_row, sob_wr_col, sob_wr_data,
        output sob_wr_gnt,
        output rd_data, oob_err,
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata
    );

    modport master (
        output vga_req, vga_row, vga_col,
        input  vga_gnt, vga_rvalid,
        output sob_rd_req, sob_rd_row, sob_rd_col,
        input  sob_rd_gnt, sob_rd_rvalid,
        output sob_wr_req, sob_wr_row, sob_wr_col, sob_wr_data,
        input  sob_wr_gnt,
        input  rd_data, oob_err,
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: VGA reader, Sobel reader and Sobel writer share
// one BRAM port. Fixed priority VGA > write > read, with starvation promotion of the
// Sobel requesters, (row, col) to linear address conversion, and a 2-deep owner tag
// that routes returning read data to its requester.
module frame_buffer_arbiter #(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    frame_buffer_arbiter_if.slave  bus
);

    localparam int unsigned       CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    // Owner tag carried alongside each issued access
    typedef struct packed {
        logic valid;   // access was a read
        logic is_vga;  // owner: 1 = VGA, 0 = Sobel reader
        logic oob;     // coordinates were out of range, data forced to zero
    } rd_tag_t;

    // Starvation wait counters
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic              wr_starved_c, rd_starved_c;

    // Grants and selected request
    logic              vga_gnt_c, wr_gnt_c, rd_gnt_c, any_gnt_c;
    logic [15:0]       sel_row_c, sel_col_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              sel_oob_c;

    // Issue stage and read return pipeline
    logic              bram_en_q, bram_en_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic [7:0]        bram_wdata_q, bram_wdata_d;
    logic              oob_err_q, oob_err_d;
    rd_tag_t           tag1_q, tag1_d;
    rd_tag_t           tag2_q, tag2_d;

    // Arbitration: starved Sobel requesters outrank VGA, write before read
    always_comb begin
        vga_gnt_c    = 1'b0;
        wr_gnt_c     = 1'b0;
        rd_gnt_c     = 1'b0;
        wr_starved_c = (wr_cnt_q == CNT_LIMIT);
        rd_starved_c = (rd_cnt_q == CNT_LIMIT);
        if (!reset) begin
            if (bus.sob_wr_req && wr_starved_c) begin
                wr_gnt_c = 1'b1;
            end else if (bus.sob_rd_req && rd_starved_c) begin
                rd_gnt_c = 1'b1;
            end else if (bus.vga_req) begin
                vga_gnt_c = 1'b1;
            end else if (bus.sob_wr_req) begin
                wr_gnt_c = 1'b1;
            end else if (bus.sob_rd_req) begin
                rd_gnt_c = 1'b1;
            end
        end
        any_gnt_c = vga_gnt_c | wr_gnt_c | rd_gnt_c;
    end

    // Coordinates of the granted request, its linear address and range check
    always_comb begin
        sel_row_c = bus.sob_rd_row;
        sel_col_c = bus.sob_rd_col;
        if (vga_gnt_c) begin
            sel_row_c = bus.vga_row;
            sel_col_c = bus.vga_col;
        end else if (wr_gnt_c) begin
            sel_row_c = bus.sob_wr_row;
            sel_col_c = bus.sob_wr_col;
        end
        sel_addr_c = ADDR_W'(32'(sel_row_c) * 32'(IMG_WIDTH) + 32'(sel_col_c));
        sel_oob_c  = (32'(sel_row_c) >= 32'(IMG_HEIGHT)) ||
                     (32'(sel_col_c) >= 32'(IMG_WIDTH));
    end

    // Wait counters: count lost cycles while requesting, saturate at the limit
    always_comb begin
        wr_cnt_d = '0;
        rd_cnt_d = '0;
        if (bus.sob_wr_req && !wr_gnt_c) begin
            wr_cnt_d = wr_starved_c ? CNT_LIMIT : wr_cnt_q + CNT_W'(1);
        end
        if (bus.sob_rd_req && !rd_gnt_c) begin
            rd_cnt_d = rd_starved_c ? CNT_LIMIT : rd_cnt_q + CNT_W'(1);
        end
    end

    // Issue stage, owner tag pipeline and sticky range error
    always_comb begin
        bram_en_d    = any_gnt_c && !sel_oob_c;
        bram_we_d    = wr_gnt_c && !sel_oob_c;
        bram_addr_d  = bram_addr_q;
        bram_wdata_d = bram_wdata_q;
        if (any_gnt_c) begin
            bram_addr_d = sel_addr_c;
        end
        if (wr_gnt_c) begin
            bram_wdata_d = bus.sob_wr_data;
        end
        tag1_d.valid  = vga_gnt_c | rd_gnt_c;
        tag1_d.is_vga = vga_gnt_c;
        tag1_d.oob    = sel_oob_c;
        tag2_d        = tag1_q;
        oob_err_d     = oob_err_q | (any_gnt_c & sel_oob_c);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_wdata_q <= '0;
            oob_err_q    <= 1'b0;
            tag1_q       <= '0;
            tag2_q       <= '0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            bram_en_q    <= bram_en_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_wdata_q <= bram_wdata_d;
            oob_err_q    <= oob_err_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
        end
    end

    assign bus.vga_gnt       = vga_gnt_c;
    assign bus.sob_wr_gnt    = wr_gnt_c;
    assign bus.sob_rd_gnt    = rd_gnt_c;
    assign bus.bram_en       = bram_en_q;
    assign bus.bram_we       = bram_we_q;
    assign bus.bram_addr     = bram_addr_q;
    assign bus.bram_wdata    = bram_wdata_q;
    assign bus.oob_err       = oob_err_q;
    assign bus.vga_rvalid    = tag2_q.valid & tag2_q.is_vga;
    assign bus.sob_rd_rvalid = tag2_q.valid & ~tag2_q.is_vga;
    // BRAM output is already registered; only the owner/OOB gating is applied here
    assign bus.rd_data       = (tag2_q.valid && !tag2_q.oob) ? bus.bram_rdata : 8'h00;

endmodule
